// File: rtl/uart_pkg.sv
// Shared constants, parser state encoding and timeout sizing for the UART packet deframer.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_LEN  = 3'd1,
        S_PAY  = 3'd2,
        S_CHK  = 3'd3,
        S_DISC = 3'd4
    } state_t;

    // One byte on the line is 10 bit times (start, 8 data, stop).
    function automatic int timeout_clks(input int clk_hz, input int bit_rate, input int tmo_bytes);
        return (clk_hz / bit_rate) * 10 * tmo_bytes;
    endfunction

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: circular DEPTH x 9 store with separate write, commit and read pointers,
// so a packet becomes visible to the reader only once its checksum has been accepted.
module uart_pkt_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [8:0]       wr_data,
    input  logic             commit,
    input  logic             rewind,
    output logic [PTR_W-1:0] free_cnt,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             rd_valid,
    input  logic             rd_ready
);

    localparam int ADDR_W = PTR_W - 1;

    logic [8:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] cm_ptr_q, cm_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [8:0]       rd_entry;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        cm_ptr_d = cm_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (rewind) begin
            wr_ptr_d = cm_ptr_q;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (commit) begin
            cm_ptr_d = wr_ptr_q;
        end
        if (rd_valid && rd_ready) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            cm_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cm_ptr_q <= cm_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only read between rd_ptr and cm_ptr.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
        end
    end

    assign free_cnt = PTR_W'(DEPTH) - (cm_ptr_q - rd_ptr_q);
    assign rd_valid = (rd_ptr_q != cm_ptr_q);
    assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
    assign rd_data  = rd_valid ? rd_entry[7:0] : 8'h00;
    assign rd_last  = rd_valid ? rd_entry[8] : 1'b0;

endmodule

// File: rtl/uart_rx_deframer.sv
// Packet deframer behind the UART receiver: parses SYNC/LEN/payload/CHK frames, buffers the
// payload and releases only checksum-verified packets; drops are flagged on one-cycle pulses.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int CLK_HZ        = 100000000,
    parameter int BIT_RATE      = 9600,
    parameter int TIMEOUT_BYTES = 2,
    parameter int DEPTH         = 64,
    parameter int MAX_LEN       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_valid,
    input  logic       uart_err,
    output logic [7:0] pkt_data,
    output logic       pkt_last,
    output logic       pkt_valid,
    input  logic       pkt_ready,
    output logic       chk_err,
    output logic       len_err,
    output logic       ovf_err,
    output logic       frm_err,
    output logic       tmo_err
);

    localparam int PTR_W    = $clog2(DEPTH) + 1;
    localparam int TMO_CLKS = timeout_clks(CLK_HZ, BIT_RATE, TIMEOUT_BYTES);
    localparam int TMO_W    = $clog2(TMO_CLKS + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CLKS - 1);
    localparam logic [8:0]       MAX_LEN_W = 9'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       rem_q, rem_d;
    logic [7:0]       sum_q, sum_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             chk_err_q, chk_err_d;
    logic             len_err_q, len_err_d;
    logic             ovf_err_q, ovf_err_d;
    logic             frm_err_q, frm_err_d;
    logic             tmo_err_q, tmo_err_d;

    logic             wr_en;
    logic [8:0]       wr_data;
    logic             commit;
    logic             rewind;
    logic [PTR_W-1:0] free_cnt;
    logic [8:0]       free_ext;
    logic [8:0]       len_ext;

    assign free_ext = 9'(free_cnt);
    assign len_ext  = {1'b0, uart_rx_data};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        sum_d     = sum_q;
        tmo_cnt_d = tmo_cnt_q;
        wr_en     = 1'b0;
        wr_data   = {(rem_q == 8'd1), uart_rx_data};
        commit    = 1'b0;
        rewind    = 1'b0;
        chk_err_d = 1'b0;
        len_err_d = 1'b0;
        ovf_err_d = 1'b0;
        frm_err_d = 1'b0;
        tmo_err_d = 1'b0;

        // A framing error outranks a simultaneous byte, which is never interpreted.
        if (uart_err) begin
            frm_err_d = 1'b1;
            if (state_q != S_SYNC) begin
                rewind  = 1'b1;
                state_d = S_SYNC;
            end
        end else if (uart_valid) begin
            case (state_q)
                S_SYNC: begin
                    if (uart_rx_data == SYNC_BYTE) begin
                        state_d = S_LEN;
                    end
                end
                S_LEN: begin
                    if (uart_rx_data == 8'd0 || len_ext > MAX_LEN_W) begin
                        len_err_d = 1'b1;
                        state_d   = S_SYNC;
                    end else begin
                        rem_d = uart_rx_data;
                        sum_d = uart_rx_data;
                        // Whole packets only: reserve space up front so a write never overflows.
                        if (len_ext > free_ext) begin
                            ovf_err_d = 1'b1;
                            state_d   = S_DISC;
                        end else begin
                            state_d = S_PAY;
                        end
                    end
                end
                S_PAY: begin
                    wr_en = 1'b1;
                    sum_d = sum_q + uart_rx_data;
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_CHK;
                    end
                end
                S_CHK: begin
                    if (uart_rx_data == sum_q) begin
                        commit = 1'b1;
                    end else begin
                        rewind    = 1'b1;
                        chk_err_d = 1'b1;
                    end
                    state_d = S_SYNC;
                end
                S_DISC: begin
                    if (rem_q == 8'd0) begin
                        state_d = S_SYNC;
                    end else begin
                        rem_d = rem_q - 8'd1;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end else if (state_q != S_SYNC) begin
            if (tmo_cnt_q == TMO_LAST) begin
                rewind    = 1'b1;
                tmo_err_d = 1'b1;
                state_d   = S_SYNC;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end

        if (uart_valid || state_d == S_SYNC) begin
            tmo_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_SYNC;
            rem_q     <= '0;
            sum_q     <= '0;
            tmo_cnt_q <= '0;
            chk_err_q <= 1'b0;
            len_err_q <= 1'b0;
            ovf_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            sum_q     <= sum_d;
            tmo_cnt_q <= tmo_cnt_d;
            chk_err_q <= chk_err_d;
            len_err_q <= len_err_d;
            ovf_err_q <= ovf_err_d;
            frm_err_q <= frm_err_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    uart_pkt_buf #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .commit   (commit),
        .rewind   (rewind),
        .free_cnt (free_cnt),
        .rd_data  (pkt_data),
        .rd_last  (pkt_last),
        .rd_valid (pkt_valid),
        .rd_ready (pkt_ready)
    );

    assign chk_err = chk_err_q;
    assign len_err = len_err_q;
    assign ovf_err = ovf_err_q;
    assign frm_err = frm_err_q;
    assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Self-checking bench for uart_rx_deframer: directed frames plus random traffic, checked
// against a packet-level model that queues the bytes each accepted frame should deliver.
module tb_uart_rx_deframer;

    localparam int CLK_HZ        = 96000;
    localparam int BIT_RATE      = 9600;
    localparam int TIMEOUT_BYTES = 2;
    localparam int DEPTH         = 64;
    localparam int MAX_LEN       = 32;
    localparam int TMO_CLKS      = (CLK_HZ / BIT_RATE) * 10 * TIMEOUT_BYTES;

    localparam logic [4:0] P_NONE = 5'b00000;
    localparam logic [4:0] P_CHK  = 5'b10000;
    localparam logic [4:0] P_LEN  = 5'b01000;
    localparam logic [4:0] P_OVF  = 5'b00100;
    localparam logic [4:0] P_FRM  = 5'b00010;
    localparam logic [4:0] P_TMO  = 5'b00001;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] uart_rx_data;
    logic       uart_valid;
    logic       uart_err;
    logic [7:0] pkt_data;
    logic       pkt_last;
    logic       pkt_valid;
    logic       pkt_ready;
    logic       chk_err;
    logic       len_err;
    logic       ovf_err;
    logic       frm_err;
    logic       tmo_err;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q[$];
    logic [8:0] pend_q[$];
    logic [4:0] exp_pulse_g;
    logic       commit_g;
    logic       rand_ready;

    uart_rx_deframer #(
        .CLK_HZ        (CLK_HZ),
        .BIT_RATE      (BIT_RATE),
        .TIMEOUT_BYTES (TIMEOUT_BYTES),
        .DEPTH         (DEPTH),
        .MAX_LEN       (MAX_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .uart_rx_data (uart_rx_data),
        .uart_valid   (uart_valid),
        .uart_err     (uart_err),
        .pkt_data     (pkt_data),
        .pkt_last     (pkt_last),
        .pkt_valid    (pkt_valid),
        .pkt_ready    (pkt_ready),
        .chk_err      (chk_err),
        .len_err      (len_err),
        .ovf_err      (ovf_err),
        .frm_err      (frm_err),
        .tmo_err      (tmo_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] csum(input logic [7:0] len, input logic [7:0] pay[$]);
        logic [7:0] s = len;
        foreach (pay[i]) s = s + pay[i];
        return s;
    endfunction

    // One clock: check the read stream before the edge, status pulses after it.
    task automatic stepCycle();
        logic acc;
        if (rand_ready) pkt_ready = ($urandom_range(0, 4) != 0);
        if (exp_q.size() != 0) begin
            checkOutput("pkt_valid", {8'b0, pkt_valid}, 9'd1);
            checkOutput("pkt_data", {1'b0, pkt_data}, {1'b0, exp_q[0][7:0]});
            checkOutput("pkt_last", {8'b0, pkt_last}, {8'b0, exp_q[0][8]});
        end else begin
            checkOutput("pkt_valid", {8'b0, pkt_valid}, 9'd0);
            checkOutput("pkt_data", {1'b0, pkt_data}, 9'd0);
            checkOutput("pkt_last", {8'b0, pkt_last}, 9'd0);
        end
        acc = (exp_q.size() != 0) && pkt_ready;
        @(posedge clk);
        #1;
        if (acc) void'(exp_q.pop_front());
        if (commit_g) begin
            foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
        end
        checkOutput("chk_err", {8'b0, chk_err}, {8'b0, exp_pulse_g[4]});
        checkOutput("len_err", {8'b0, len_err}, {8'b0, exp_pulse_g[3]});
        checkOutput("ovf_err", {8'b0, ovf_err}, {8'b0, exp_pulse_g[2]});
        checkOutput("frm_err", {8'b0, frm_err}, {8'b0, exp_pulse_g[1]});
        checkOutput("tmo_err", {8'b0, tmo_err}, {8'b0, exp_pulse_g[0]});
        exp_pulse_g = P_NONE;
        commit_g    = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input logic v, input logic e,
                                 input logic [4:0] pulse, input logic commit, input int max_gap);
        uart_rx_data = b;
        uart_valid   = v;
        uart_err     = e;
        exp_pulse_g  = pulse;
        commit_g     = commit;
        stepCycle();
        uart_rx_data = 8'h00;
        uart_valid   = 1'b0;
        uart_err     = 1'b0;
        if (max_gap > 0) repeat (int'($urandom_range(0, max_gap))) stepCycle();
    endtask

    // Frame-level model: outcome decided from LEN, free space and the checksum rule.
    task automatic sendFrame(input logic [7:0] len_b, input logic [7:0] pay[$],
                             input logic [7:0] chk_b, input int max_gap);
        logic lst;
        applyStimulus(8'hA5, 1'b1, 1'b0, P_NONE, 1'b0, max_gap);
        if (len_b == 8'd0 || int'(len_b) > MAX_LEN) begin
            applyStimulus(len_b, 1'b1, 1'b0, P_LEN, 1'b0, max_gap);
            return;
        end
        if (DEPTH - exp_q.size() < int'(len_b)) begin
            applyStimulus(len_b, 1'b1, 1'b0, P_OVF, 1'b0, max_gap);
            foreach (pay[i]) applyStimulus(pay[i], 1'b1, 1'b0, P_NONE, 1'b0, max_gap);
            applyStimulus(chk_b, 1'b1, 1'b0, P_NONE, 1'b0, max_gap);
            return;
        end
        applyStimulus(len_b, 1'b1, 1'b0, P_NONE, 1'b0, max_gap);
        pend_q.delete();
        foreach (pay[i]) begin
            lst = (i == pay.size() - 1);
            pend_q.push_back({lst, pay[i]});
        end
        foreach (pay[i]) applyStimulus(pay[i], 1'b1, 1'b0, P_NONE, 1'b0, max_gap);
        if (chk_b == csum(len_b, pay))
            applyStimulus(chk_b, 1'b1, 1'b0, P_NONE, 1'b1, max_gap);
        else
            applyStimulus(chk_b, 1'b1, 1'b0, P_CHK, 1'b0, max_gap);
    endtask

    task automatic drain();
        int n = 0;
        rand_ready = 1'b0;
        pkt_ready  = 1'b1;
        while (exp_q.size() != 0 && n < 500) begin
            stepCycle();
            n++;
        end
        stepCycle();
    endtask

    task automatic randPayload(input int len, output logic [7:0] pay[$]);
        pay.delete();
        for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_valid"}, {8'b0, pkt_valid}, 9'd0);
        checkOutput({tag, "_data"}, {1'b0, pkt_data}, 9'd0);
        checkOutput({tag, "_last"}, {8'b0, pkt_last}, 9'd0);
        checkOutput({tag, "_errs"}, {4'b0, chk_err, len_err, ovf_err, frm_err, tmo_err}, 9'd0);
    endtask

    initial begin
        logic [7:0] pay[$];
        logic [7:0] len;
        int         kind;

        reset        = 1'b0;
        uart_rx_data = 8'h00;
        uart_valid   = 1'b0;
        uart_err     = 1'b0;
        pkt_ready    = 1'b0;
        rand_ready   = 1'b0;
        exp_pulse_g  = P_NONE;
        commit_g     = 1'b0;
        #1;
        checkResetOutputs("reset");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) stepCycle();

        $display("[TB] good packet");
        pkt_ready = 1'b1;
        pay = '{8'h11, 8'h22, 8'h33};
        sendFrame(8'h03, pay, 8'h69, 0);
        drain();

        $display("[TB] bad checksum then good packet");
        pay = '{8'hAA, 8'hBB};
        sendFrame(8'h02, pay, 8'h00, 0);
        pay = '{8'h5A};
        sendFrame(8'h01, pay, 8'h5B, 0);
        drain();

        $display("[TB] length errors");
        pay.delete();
        sendFrame(8'h00, pay, 8'h00, 0);
        sendFrame(8'h21, pay, 8'h00, 0);
        pay = '{8'hA5, 8'h01};
        sendFrame(8'h02, pay, csum(8'h02, pay), 0);
        drain();

        $display("[TB] overflow");
        pkt_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            randPayload(32, pay);
            sendFrame(8'd32, pay, csum(8'd32, pay), 1);
        end
        pay = '{8'h07};
        sendFrame(8'h01, pay, 8'h08, 0);
        drain();
        sendFrame(8'h01, pay, 8'h08, 0);
        drain();

        $display("[TB] timeout");
        pkt_ready = 1'b1;
        applyStimulus(8'hA5, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h04, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h01, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h02, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        for (int k = 1; k <= TMO_CLKS + 5; k++) begin
            exp_pulse_g = (k == TMO_CLKS) ? P_TMO : P_NONE;
            stepCycle();
        end
        pay = '{8'h3C, 8'hC3};
        sendFrame(8'h02, pay, csum(8'h02, pay), 0);
        drain();

        $display("[TB] framing errors");
        applyStimulus(8'hA5, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h03, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h10, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h20, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h00, 1'b0, 1'b1, P_FRM, 1'b0, 0);
        applyStimulus(8'h30, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h63, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'hA5, 1'b1, 1'b1, P_FRM, 1'b0, 0);
        applyStimulus(8'h01, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h5A, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        applyStimulus(8'h5B, 1'b1, 1'b0, P_NONE, 1'b0, 0);
        pay = '{8'h99};
        sendFrame(8'h01, pay, 8'h9A, 0);
        drain();

        $display("[TB] backpressure");
        pkt_ready = 1'b0;
        randPayload(6, pay);
        sendFrame(8'h06, pay, csum(8'h06, pay), 0);
        pkt_ready = 1'b1;
        repeat (2) stepCycle();
        pkt_ready = 1'b0;
        repeat (10) stepCycle();
        drain();

        $display("[TB] random traffic");
        rand_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 9));
            len  = 8'($urandom_range(1, 12));
            randPayload(int'(len), pay);
            if ($urandom_range(0, 3) == 0)
                applyStimulus(8'($urandom_range(0, 127)), 1'b1, 1'b0, P_NONE, 1'b0, 2);
            if (kind == 0) begin
                pay.delete();
                len = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255));
                sendFrame(len, pay, 8'h00, 3);
            end else if (kind <= 2) begin
                sendFrame(len, pay, csum(len, pay) + 8'($urandom_range(1, 255)), 3);
            end else begin
                sendFrame(len, pay, csum(len, pay), 3);
            end
        end
        drain();

        $display("[TB] reset while valid");
        pkt_ready = 1'b0;
        pay = '{8'h44, 8'h55};
        sendFrame(8'h02, pay, csum(8'h02, pay), 0);
        stepCycle();
        reset = 1'b0;
        #1;
        checkResetOutputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) stepCycle();
        pay = '{8'h12, 8'h34, 8'h56};
        sendFrame(8'h03, pay, csum(8'h03, pay), 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
